fim_rdack_rr_arb: RTL and testbench

- Round-robin arbiter that drains NUM_PORTS rdack-style FIFOs (rvalid/rdata/rdack, data held until acked) into one registered valid/ready output stream.
- Sits between per-requester rdack FIFOs and a shared downstream consumer, for example a single TX pipeline.
- Optional packet lock keeps a packet's beats contiguous: a grant is held from the first beat through the EOP beat.

---
 rtl/fim_arb_pkg.sv | 26 ++
 rtl/fim_rr_pick.sv | 33 +++
 rtl/fim_rdack_rr_arb.sv | 119 +++++++++++
 tb/tb_fim_rdack_rr_arb.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fim_arb_pkg.sv
// Shared types and the rotating-priority search used by the rdack round-robin arbiter.
package fim_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } t_arb_state;

  localparam int MAX_PORTS = 16;

  // Returns {found, idx}: first set bit of valid_vec after last_ptr, wrapping at num_ports.
  function automatic logic [4:0] rr_next(input logic [15:0] valid_vec,
                                         input logic [3:0]  last_ptr,
                                         input int          num_ports);
    logic [4:0] res;
    int         idx;
    res = '0;
    for (int k = 1; k <= MAX_PORTS; k++) begin
      idx = int'(last_ptr) + k;
      if (idx >= num_ports) idx = idx - num_ports;
      if (k <= num_ports && !res[4] && valid_vec[idx[3:0]]) res = {1'b1, idx[3:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/fim_rr_pick.sv
// Combinational rotating priority encoder: one-hot grant and index of the next requester after last_ptr.
module fim_rr_pick
  import fim_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    last_ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PORT_W-1:0]    idx,
  output logic                 found
);

  logic [15:0] req_ext;
  logic [3:0]  last_ext;
  logic [4:0]  res;

  always_comb begin
    req_ext                 = '0;
    req_ext[NUM_PORTS-1:0]  = req;
    last_ext                = '0;
    last_ext[PORT_W-1:0]    = last_ptr;
    res                     = rr_next(req_ext, last_ext, NUM_PORTS);
    found                   = res[4];
    idx                     = res[PORT_W-1:0];
    grant                   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      grant[i] = res[4] && (res[3:0] == 4'(i));
    end
  end

endmodule

// File: rtl/fim_rdack_rr_arb.sv
// Round-robin arbiter draining NUM_PORTS rdack-style FIFOs into one registered valid/ready stream,
// optionally holding the grant for a whole packet (PKT_MODE=1).
module fim_rdack_rr_arb
  import fim_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int PKT_MODE   = 1,
  parameter int EOP_BIT    = DATA_WIDTH - 1,
  parameter int PORT_W     = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            in_rvalid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_rdata,
  output logic [NUM_PORTS-1:0]            in_rdack,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [PORT_W-1:0]               out_port,
  input  logic                            out_ready,
  output logic                            locked
);

  t_arb_state state, state_nxt;
  logic [PORT_W-1:0]     last_ptr, last_ptr_nxt;
  logic [PORT_W-1:0]     lock_port, lock_port_nxt;
  logic                  locked_nxt;
  logic [NUM_PORTS-1:0]  pick_grant;
  logic [PORT_W-1:0]     pick_idx;
  logic                  pick_found;
  logic [NUM_PORTS-1:0]  lock_onehot;
  logic [NUM_PORTS-1:0]  grant_vec;
  logic [PORT_W-1:0]     g;
  logic                  have_grant;
  logic                  can_load;
  logic                  accept;
  logic                  eop;
  logic [DATA_WIDTH-1:0] sel_data;

  fim_rr_pick #(
    .NUM_PORTS(NUM_PORTS),
    .PORT_W   (PORT_W)
  ) u_pick (
    .req     (in_rvalid),
    .last_ptr(last_ptr),
    .grant   (pick_grant),
    .idx     (pick_idx),
    .found   (pick_found)
  );

  // While locked only the packet owner competes; rst gates rdack so no beat is lost into a resetting stage.
  always_comb begin
    can_load = ~out_valid | out_ready;
    for (int i = 0; i < NUM_PORTS; i++) begin
      lock_onehot[i] = (PORT_W'(i) == lock_port);
    end
    if (state == LOCK) begin
      g          = lock_port;
      have_grant = in_rvalid[lock_port];
      grant_vec  = lock_onehot;
    end else begin
      g          = pick_idx;
      have_grant = pick_found;
      grant_vec  = pick_grant;
    end
    accept   = have_grant & can_load & ~rst;
    in_rdack = accept ? grant_vec : '0;
    sel_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (PORT_W'(i) == g) sel_data = in_rdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
    eop = sel_data[EOP_BIT];
  end

  always_comb begin
    state_nxt     = state;
    last_ptr_nxt  = last_ptr;
    lock_port_nxt = lock_port;
    if (accept) begin
      if (PKT_MODE != 0 && !eop) begin
        state_nxt     = LOCK;
        lock_port_nxt = g;
      end else begin
        state_nxt    = ARB;
        last_ptr_nxt = g;
      end
    end
    locked_nxt = (state_nxt == LOCK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB;
      last_ptr  <= PORT_W'(NUM_PORTS - 1);
      lock_port <= '0;
      locked    <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_ptr  <= last_ptr_nxt;
      lock_port <= lock_port_nxt;
      locked    <= locked_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_port  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_port  <= g;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fim_rdack_rr_arb.sv
// Self-checking bench: bench-side FIFO models feed the arbiter, a packet-level round-robin model predicts the output order.
module tb_fim_rdack_rr_arb;

  localparam int NP = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] in_rvalid, in_rdack;
  logic [NP*DW-1:0] in_rdata;
  logic          out_valid, out_ready, locked;
  logic [DW-1:0] out_data;
  logic [1:0]    out_port;

  logic [NP-1:0] rvalid_m0, rdack_m0;
  logic [NP*DW-1:0] rdata_m0;
  logic          valid_m0, ready_m0, locked_m0;
  logic [DW-1:0] data_m0;
  logic [1:0]    port_m0;

  fim_rdack_rr_arb #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .PKT_MODE(1)) dut (
    .clk(clk), .rst(rst), .in_rvalid(in_rvalid), .in_rdata(in_rdata), .in_rdack(in_rdack),
    .out_valid(out_valid), .out_data(out_data), .out_port(out_port), .out_ready(out_ready),
    .locked(locked)
  );

  fim_rdack_rr_arb #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .PKT_MODE(0)) dut_m0 (
    .clk(clk), .rst(rst), .in_rvalid(rvalid_m0), .in_rdata(rdata_m0), .in_rdack(rdack_m0),
    .out_valid(valid_m0), .out_data(data_m0), .out_port(port_m0), .out_ready(ready_m0),
    .locked(locked_m0)
  );

  always #5 clk = ~clk;

  logic [31:0] src_mem [NP][64];
  int          src_head [NP];
  int          src_tail [NP];
  int          pkt_len [NP][16];
  int          pkt_cnt [NP];
  bit          hold [NP];
  logic [31:0] exp_q [$];
  bit          mid_pkt;
  bit          ready_rand;
  bit          ready_fixed;
  int          seq;
  int          n_cmp;
  int          n_bad;
  logic          s_valid, s_locked;
  logic [NP-1:0] s_rdack;
  logic [DW-1:0] s_data;
  logic [1:0]    s_port;

  task automatic clear_model();
    for (int i = 0; i < NP; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
      pkt_cnt[i]  = 0;
      hold[i]     = 1'b0;
    end
    exp_q.delete();
    mid_pkt = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_rvalid = '0;
    rvalid_m0 = '0;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_pkt(input int port, input int len);
    for (int b = 0; b < len; b++) begin
      src_mem[port][src_tail[port]] = {(b == len - 1), 3'b000, 4'(port), 8'($urandom), 16'(seq)};
      src_tail[port]++;
      seq++;
    end
    pkt_len[port][pkt_cnt[port]] = len;
    pkt_cnt[port]++;
  endtask

  // Packet-level model: every queued packet goes out whole, ports visited in rotating order after the last one served.
  task automatic build_expected(input int last_start);
    int  last;
    int  pidx [NP];
    int  pos [NP];
    bit  found;
    last = last_start;
    for (int i = 0; i < NP; i++) begin
      pidx[i] = 0;
      pos[i]  = src_head[i];
    end
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      for (int k = 1; k <= NP; k++) begin
        int p;
        p = (last + k) % NP;
        if (!found && pidx[p] < pkt_cnt[p]) begin
          for (int b = 0; b < pkt_len[p][pidx[p]]; b++) begin
            exp_q.push_back(src_mem[p][pos[p]]);
            pos[p]++;
          end
          pidx[p]++;
          last  = p;
          found = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    logic [31:0] expv;
    @(negedge clk);
    for (int i = 0; i < NP; i++) begin
      in_rvalid[i]        = (src_head[i] != src_tail[i]) && !hold[i];
      in_rdata[i*DW +: DW] = (src_head[i] != src_tail[i]) ? src_mem[i][src_head[i]] : '0;
    end
    out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_fixed;
    #1;
    s_valid  = out_valid;
    s_rdack  = in_rdack;
    s_data   = out_data;
    s_port   = out_port;
    s_locked = locked;
    n_cmp++;
    if ((in_rdack & ~in_rvalid) != '0 || $countones(in_rdack) > 1) begin
      n_bad++;
      $display("[TB] FAIL rdack_legal: rdack=%b rvalid=%b", in_rdack, in_rvalid);
    end
    n_cmp++;
    if (out_valid && !out_ready && in_rdack != '0) begin
      n_bad++;
      $display("[TB] FAIL rdack_backpressure: rdack=%b required 0000", in_rdack);
    end
    n_cmp++;
    if (locked !== mid_pkt) begin
      n_bad++;
      $display("[TB] FAIL locked: got %b want %b", locked, mid_pkt);
    end
    if (out_valid === 1'b1 && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("[TB] FAIL extra_beat: got data %h with nothing expected", out_data);
      end else begin
        expv = exp_q.pop_front();
        if (out_data !== expv || {2'b00, out_port} !== expv[27:24]) begin
          n_bad++;
          $display("[TB] FAIL beat: got data %h port %0d want data %h port %0d",
                   out_data, out_port, expv, expv[27:24]);
        end
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (in_rdack[i] === 1'b1 && src_head[i] != src_tail[i]) begin
        expv    = src_mem[i][src_head[i]];
        mid_pkt = !expv[31];
        src_head[i]++;
      end
    end
    @(posedge clk);
  endtask

  task automatic drain(input int budget);
    int  c;
    bit  src_left;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      step();
      c++;
    end
    src_left = 1'b0;
    for (int i = 0; i < NP; i++) if (src_head[i] != src_tail[i]) src_left = 1'b1;
    n_cmp++;
    if (exp_q.size() != 0 || src_left) begin
      n_bad++;
      $display("[TB] FAIL drain: %0d beats still expected, sources left=%b after %0d cycles",
               exp_q.size(), src_left, c);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_rvalid = '1;
    rvalid_m0 = '1;
    in_rdata  = {4{32'hA5A5_0001}};
    rdata_m0  = {4{32'h0000_0003}};
    out_ready = 1'b1;
    ready_m0  = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_port !== 2'd0 || locked !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs: valid=%b data=%h port=%0d locked=%b want all zero",
               out_valid, out_data, out_port, locked);
    end
    n_cmp++;
    if (in_rdack !== '0 || rdack_m0 !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_rdack: got %b/%b want 0000", in_rdack, rdack_m0);
    end
    n_cmp++;
    if (valid_m0 !== 1'b0 || locked_m0 !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_m0: valid=%b locked=%b want 0", valid_m0, locked_m0);
    end
    in_rvalid = '0;
    rvalid_m0 = '0;
    clear_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_port();
    do_reset();
    ready_rand  = 1'b0;
    ready_fixed = 1'b1;
    for (int k = 0; k < 8; k++) push_pkt(0, 1);
    build_expected(NP - 1);
    for (int c = 0; c < 8; c++) begin
      step();
      n_cmp++;
      if (s_rdack !== 4'b0001) begin
        n_bad++;
        $display("[TB] FAIL single_rdack: cycle %0d got %b want 0001", c, s_rdack);
      end
      if (c >= 1) begin
        n_cmp++;
        if (s_valid !== 1'b1 || s_port !== 2'd0) begin
          n_bad++;
          $display("[TB] FAIL single_out: cycle %0d valid=%b port=%0d want 1/0", c, s_valid, s_port);
        end
      end
    end
    drain(20);
  endtask

  task automatic test_all_ports();
    do_reset();
    ready_rand  = 1'b0;
    ready_fixed = 1'b1;
    for (int p = 0; p < NP; p++) push_pkt(p, 3);
    push_pkt(0, 3);
    build_expected(NP - 1);
    for (int c = 0; c < 16; c++) begin
      step();
      if (c >= 1 && c <= 15) begin
        n_cmp++;
        if (s_valid !== 1'b1) begin
          n_bad++;
          $display("[TB] FAIL all_ports_gap: cycle %0d valid=%b want 1", c, s_valid);
        end
      end
    end
    drain(40);
  endtask

  task automatic test_stall_lock();
    do_reset();
    ready_rand  = 1'b0;
    ready_fixed = 1'b1;
    push_pkt(1, 3);
    push_pkt(2, 1);
    build_expected(NP - 1);
    for (int c = 0; c < 2; c++) begin
      step();
      n_cmp++;
      if (s_rdack !== 4'b0010) begin
        n_bad++;
        $display("[TB] FAIL stall_start: cycle %0d rdack=%b want 0010", c, s_rdack);
      end
    end
    hold[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      n_cmp++;
      if (s_rdack !== 4'b0000 || s_locked !== 1'b1) begin
        n_bad++;
        $display("[TB] FAIL stall_hold: cycle %0d rdack=%b locked=%b want 0000/1", c, s_rdack, s_locked);
      end
      if (c == 4) begin
        n_cmp++;
        if (s_valid !== 1'b0) begin
          n_bad++;
          $display("[TB] FAIL stall_drain: valid=%b want 0", s_valid);
        end
      end
    end
    hold[1] = 1'b0;
    step();
    n_cmp++;
    if (s_rdack !== 4'b0010) begin
      n_bad++;
      $display("[TB] FAIL stall_resume: rdack=%b want 0010", s_rdack);
    end
    step();
    n_cmp++;
    if (s_rdack !== 4'b0100) begin
      n_bad++;
      $display("[TB] FAIL stall_next: rdack=%b want 0100", s_rdack);
    end
    drain(20);
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held_d;
    logic [1:0]    held_p;
    do_reset();
    ready_rand  = 1'b0;
    ready_fixed = 1'b1;
    for (int k = 0; k < 3; k++) push_pkt(2, 2);
    push_pkt(3, 1);
    push_pkt(3, 1);
    build_expected(NP - 1);
    step();
    step();
    ready_fixed = 1'b0;
    step();
    held_d = s_data;
    held_p = s_port;
    n_cmp++;
    if (s_valid !== 1'b1 || s_rdack !== 4'b0000) begin
      n_bad++;
      $display("[TB] FAIL bp_enter: valid=%b rdack=%b want 1/0000", s_valid, s_rdack);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if (s_data !== held_d || s_port !== held_p || s_rdack !== 4'b0000) begin
        n_bad++;
        $display("[TB] FAIL bp_hold: data=%h port=%0d rdack=%b want %h/%0d/0000",
                 s_data, s_port, s_rdack, held_d, held_p);
      end
    end
    ready_fixed = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if (s_rdack == 4'b0000) begin
        n_bad++;
        $display("[TB] FAIL bp_resume: cycle %0d rdack=%b want a grant", c, s_rdack);
      end
    end
    drain(40);
  endtask

  task automatic test_random(input int iter);
    do_reset();
    ready_rand = 1'b1;
    for (int p = 0; p < NP; p++) begin
      int n;
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) push_pkt(p, $urandom_range(1, 4));
    end
    push_pkt($urandom_range(0, NP - 1), $urandom_range(1, 4));
    build_expected(NP - 1);
    drain(600);
    ready_rand = 1'b0;
    $display("[TB] random iteration %0d done", iter);
  endtask

  task automatic test_pkt_mode0();
    logic [3:0]    one;
    int            exp_g;
    int            prev_g;
    logic [DW-1:0] prev_d;
    do_reset();
    one    = 4'b0001;
    prev_g = 0;
    prev_d = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rvalid_m0 = 4'b1001;
      for (int i = 0; i < NP; i++) rdata_m0[i*DW +: DW] = $urandom;
      ready_m0 = 1'b1;
      #1;
      exp_g = (c % 2 == 0) ? 0 : 3;
      n_cmp++;
      if (rdack_m0 !== (one << exp_g)) begin
        n_bad++;
        $display("[TB] FAIL m0_rdack: cycle %0d got %b want %b", c, rdack_m0, one << exp_g);
      end
      if (c > 0) begin
        n_cmp++;
        if (valid_m0 !== 1'b1 || port_m0 !== 2'(prev_g) || data_m0 !== prev_d) begin
          n_bad++;
          $display("[TB] FAIL m0_out: cycle %0d valid=%b port=%0d data=%h want 1/%0d/%h",
                   c, valid_m0, port_m0, data_m0, prev_g, prev_d);
        end
      end
      n_cmp++;
      if (locked_m0 !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL m0_locked: got %b want 0", locked_m0);
      end
      prev_g = exp_g;
      prev_d = rdata_m0[exp_g*DW +: DW];
      @(posedge clk);
    end
    rvalid_m0 = '0;
  endtask

  task automatic test_reset_midpkt();
    do_reset();
    ready_rand  = 1'b0;
    ready_fixed = 1'b1;
    push_pkt(1, 1);
    push_pkt(2, 4);
    build_expected(NP - 1);
    repeat (3) step();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || locked !== 1'b0 || in_rdack !== 4'b0000) begin
      n_bad++;
      $display("[TB] FAIL midpkt_reset: valid=%b locked=%b rdack=%b want 0/0/0000",
               out_valid, locked, in_rdack);
    end
    in_rvalid = '0;
    exp_q.delete();
    mid_pkt = 1'b0;
    push_pkt(0, 1);
    exp_q.push_back(src_mem[0][0]);
    exp_q.push_back(src_mem[2][src_head[2]]);
    exp_q.push_back(src_mem[2][src_head[2] + 1]);
    @(negedge clk);
    rst = 1'b0;
    step();
    n_cmp++;
    if (s_rdack !== 4'b0001) begin
      n_bad++;
      $display("[TB] FAIL midpkt_priority: rdack=%b want 0001", s_rdack);
    end
    drain(20);
  endtask

  initial begin
    rst         = 1'b1;
    in_rvalid   = '0;
    in_rdata    = '0;
    out_ready   = 1'b0;
    rvalid_m0   = '0;
    rdata_m0    = '0;
    ready_m0    = 1'b0;
    ready_rand  = 1'b0;
    ready_fixed = 1'b1;
    seq         = 0;
    n_cmp       = 0;
    n_bad       = 0;
    clear_model();
    test_reset();
    test_single_port();
    test_all_ports();
    test_stall_lock();
    test_backpressure();
    for (int r = 0; r < 6; r++) test_random(r);
    test_pkt_mode0();
    test_reset_midpkt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
